// File: rtl/kyber_pkg.sv
// Shared definitions for the polynomial byte-encoding path: ring constants,
// encoder state encoding and the d-width legality rule.
package kyber_pkg;

  localparam int unsigned KYBER_N = 256;
  localparam int unsigned KYBER_Q = 3329;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } enc_state_t;

  function automatic logic d_is_legal(input logic [3:0] d, input int unsigned max_d);
    return (d != 4'd0) && (32'(d) <= max_d);
  endfunction

endpackage

// File: rtl/bit_packer.sv
// LSB-first bit accumulator: appends the low d bits of a pushed value above the
// bits already held, and drops the oldest byte on pop.
module bit_packer #(
  parameter int unsigned MAX_D = 12,
  parameter int unsigned ACC_W = MAX_D + 8,
  parameter int unsigned CNT_W = $clog2(ACC_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [3:0]       d,
  input  logic [MAX_D-1:0] push_data,
  output logic [7:0]       byte_out,
  output logic [CNT_W-1:0] bit_cnt
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] mask;
  logic [ACC_W-1:0] field;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    mask      = (ACC_W'(1) << d) - ACC_W'(1);
    field     = (ACC_W'(push_data) & mask) << bit_cnt_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    if (clear) begin
      acc_d     = '0;
      bit_cnt_d = '0;
    end else if (push) begin
      acc_d     = acc_q | field;
      bit_cnt_d = bit_cnt_q + CNT_W'(d);
    end else if (pop) begin
      acc_d     = acc_q >> 8;
      bit_cnt_d = bit_cnt_q - CNT_W'(8);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign byte_out = acc_q[7:0];
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/byte_encode_stream.sv
// Streaming ByteEncode_d: takes 256 coefficients over a valid/ready port and
// emits 32*d packed bytes over a second valid/ready port, d chosen per polynomial.
module byte_encode_stream
  import kyber_pkg::*;
#(
  parameter int unsigned COEFF_W  = 16,
  parameter int unsigned MAX_D    = 12,
  parameter int unsigned N_COEFFS = KYBER_N,
  parameter int unsigned Q        = KYBER_Q
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         d_sel,
  input  logic [COEFF_W-1:0] coeff,
  input  logic               coeff_valid,
  output logic               coeff_ready,
  output logic [7:0]         byte_data,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               byte_last,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               range_err
);

  localparam int unsigned ACC_W   = MAX_D + 8;
  localparam int unsigned CNT_W   = $clog2(ACC_W + 1);
  localparam int unsigned BYTE_W  = $clog2(32 * MAX_D);
  localparam int unsigned CCNT_W  = $clog2(N_COEFFS + 1);

  enc_state_t        state_q, state_d;
  logic [3:0]        d_q, d_d;
  logic [CCNT_W-1:0] coeff_cnt_q, coeff_cnt_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              range_err_q, range_err_d;
  logic              cfg_err_q, cfg_err_d;

  logic [CNT_W-1:0]  bit_cnt;
  logic [8:0]        d_bytes;
  logic [BYTE_W-1:0] last_idx;
  logic              start_ok;
  logic              coeff_acc;
  logic              byte_acc;

  assign d_bytes     = {d_q, 5'd0};
  assign last_idx    = BYTE_W'(d_bytes - 9'd1);
  assign coeff_ready = (state_q == RUN) && (bit_cnt < CNT_W'(8))
                       && (coeff_cnt_q < CCNT_W'(N_COEFFS));
  assign byte_valid  = (state_q != IDLE) && (bit_cnt >= CNT_W'(8));
  assign byte_last   = byte_valid && (byte_cnt_q == last_idx);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign cfg_err     = cfg_err_q;
  assign range_err   = range_err_q;

  assign start_ok  = (state_q == IDLE) && start && d_is_legal(d_sel, MAX_D);
  assign coeff_acc = coeff_valid && coeff_ready;
  assign byte_acc  = byte_valid && byte_ready;

  bit_packer #(
    .MAX_D(MAX_D),
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .push     (coeff_acc),
    .pop      (byte_acc),
    .d        (d_q),
    .push_data(coeff[MAX_D-1:0]),
    .byte_out (byte_data),
    .bit_cnt  (bit_cnt)
  );

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    coeff_cnt_d = coeff_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    range_err_d = range_err_q;
    cfg_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d     = RUN;
          d_d         = d_sel;
          coeff_cnt_d = '0;
          byte_cnt_d  = '0;
          range_err_d = 1'b0;
        end else if (start) begin
          cfg_err_d = 1'b1;
        end
      end
      RUN, FLUSH: begin
        if (coeff_acc) begin
          coeff_cnt_d = coeff_cnt_q + CCNT_W'(1);
          if ((32'(d_q) == MAX_D) && (32'(coeff) >= Q)) range_err_d = 1'b1;
          if (coeff_cnt_d == CCNT_W'(N_COEFFS)) state_d = FLUSH;
        end
        // The final byte can only form after the last accept, but a last
        // handshake is honoured in either state so the FSM can never stall.
        if (byte_acc) begin
          byte_cnt_d = byte_cnt_q + BYTE_W'(1);
          if (byte_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      d_q         <= '0;
      coeff_cnt_q <= '0;
      byte_cnt_q  <= '0;
      range_err_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      coeff_cnt_q <= coeff_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      range_err_q <= range_err_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_byte_encode_stream.sv
// Self-checking bench for byte_encode_stream: a bitstream-level packing model
// supplies expected bytes; one negedge process checks every output cycle.
module tb_byte_encode_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  d_sel = '0;
  logic [15:0] coeff = '0;
  logic        coeff_valid = 1'b0;
  logic        coeff_ready;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic        byte_last;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        range_err;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] coeffs[256];
  logic [7:0]  model_q[$];
  logic [7:0]  exp_q[$];
  int          exp_idx = 0;
  int          cur_d = 1;
  bit          rand_ready = 1'b0;
  bit          chk_en = 1'b0;

  byte_encode_stream #(
    .COEFF_W (16),
    .MAX_D   (12),
    .N_COEFFS(256),
    .Q       (3329)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .d_sel      (d_sel),
    .coeff      (coeff),
    .coeff_valid(coeff_valid),
    .coeff_ready(coeff_ready),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .range_err  (range_err)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    byte_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
  end

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Bit p of the encoded stream is bit (p mod d) of coefficient (p div d).
  function automatic void build_model(input int d);
    logic [7:0] b;
    int p;
    model_q.delete();
    for (int k = 0; k < 32 * d; k++) begin
      b = '0;
      for (int j = 0; j < 8; j++) begin
        p = 8 * k + j;
        b[j] = coeffs[p / d][p % d];
      end
      model_q.push_back(b);
    end
  endfunction

  bit         prev_stall = 1'b0;
  bit         prev_last_hs = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_lastv = 1'b0;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (!rst_n || !chk_en) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_stall) begin
        check(byte_valid == 1'b1, "stall_valid_held", byte_valid, 1);
        check(byte_data == prev_data, "stall_data_held", byte_data, prev_data);
        check(byte_last == prev_lastv, "stall_last_held", byte_last, prev_lastv);
      end
      check(done == prev_last_hs, "done_pulse", done, prev_last_hs);
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_byte", byte_data, 0);
        end else begin
          exp_b = exp_q.pop_front();
          check(byte_data == exp_b, "byte_data", byte_data, exp_b);
          check(byte_last == (exp_idx == 32 * cur_d - 1), "byte_last", byte_last,
                longint'(exp_idx == 32 * cur_d - 1));
          exp_idx++;
        end
      end else if (!byte_valid) begin
        check(byte_last == 1'b0, "last_without_valid", byte_last, 0);
      end
      prev_stall   = byte_valid && !byte_ready;
      prev_data    = byte_data;
      prev_lastv   = byte_last;
      prev_last_hs = byte_valid && byte_ready && byte_last;
    end
  end

  task automatic check_all_zero(input string tag);
    check(coeff_ready == 0, {tag, "_coeff_ready"}, coeff_ready, 0);
    check(byte_valid == 0, {tag, "_byte_valid"}, byte_valid, 0);
    check(byte_data == 0, {tag, "_byte_data"}, byte_data, 0);
    check(byte_last == 0, {tag, "_byte_last"}, byte_last, 0);
    check(busy == 0, {tag, "_busy"}, busy, 0);
    check(done == 0, {tag, "_done"}, done, 0);
    check(cfg_err == 0, {tag, "_cfg_err"}, cfg_err, 0);
    check(range_err == 0, {tag, "_range_err"}, range_err, 0);
  endtask

  // Runs one polynomial from start; feeds n_feed coefficients; waits for done
  // only when all 256 are fed. busy_start_at>=0 pulses a legal start mid-run.
  task automatic run_poly(input int d, input int n_feed, input int busy_start_at, input bit gaps);
    int i;
    int guard;
    bit acc;
    bit exp_rerr;
    i = 0;
    guard = 0;
    exp_rerr = 1'b0;
    cur_d = d;
    exp_idx = 0;
    build_model(d);
    exp_q = model_q;
    for (int k = 0; k < n_feed; k++)
      if (d == 12 && coeffs[k] >= 16'd3329) exp_rerr = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    d_sel = 4'(d);
    @(posedge clk); #1;
    start = 1'b0;
    check(busy == 1'b1, "busy_after_start", busy, 1);
    coeff = coeffs[0];
    coeff_valid = gaps ? ($urandom % 4 != 0) : 1'b1;
    while (i < n_feed && guard < 20000) begin
      @(negedge clk);
      acc = coeff_valid && coeff_ready;
      @(posedge clk); #1;
      guard++;
      start = 1'b0;
      if (acc) i++;
      if (acc && i == busy_start_at) begin
        start = 1'b1;
        d_sel = 4'd3;
      end
      if (i < n_feed) begin
        coeff = coeffs[i];
        coeff_valid = gaps ? ($urandom % 4 != 0) : 1'b1;
      end else begin
        coeff_valid = 1'b0;
      end
    end
    start = 1'b0;
    coeff_valid = 1'b0;
    if (guard >= 20000) check(1'b0, "feed_timeout", i, n_feed);
    if (n_feed == 256) begin
      guard = 0;
      while (done !== 1'b1 && guard < 20000) begin
        @(negedge clk);
        guard++;
      end
      check(done == 1'b1, "done_seen", done, 1);
      check(exp_q.size() == 0, "bytes_remaining", exp_q.size(), 0);
      check(exp_idx == 32 * d, "byte_count", exp_idx, 32 * d);
      check(range_err == exp_rerr, "range_err", range_err, exp_rerr);
      check(busy == 1'b1, "busy_in_done", busy, 1);
      check(coeff_ready == 1'b0, "no_ready_in_done", coeff_ready, 0);
      @(negedge clk);
      check(busy == 1'b0, "idle_after_done", busy, 0);
      check(done == 1'b0, "done_one_cycle", done, 0);
    end
  endtask

  task automatic cfg_bad(input int d);
    @(posedge clk); #1;
    start = 1'b1;
    d_sel = 4'(d);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check(cfg_err == 1'b1, "cfg_err_pulse", cfg_err, 1);
    check(busy == 1'b0, "cfg_err_busy", busy, 0);
    @(negedge clk);
    check(cfg_err == 1'b0, "cfg_err_clears", cfg_err, 0);
    check(busy == 1'b0, "cfg_err_stays_idle", busy, 0);
  endtask

  initial begin
    int rd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Pin the model with hand-derived encodings.
    for (int k = 0; k < 256; k++) coeffs[k] = 16'(k);
    build_model(12);
    check(model_q.size() == 384, "model_d12_len", model_q.size(), 384);
    check(model_q[0] == 8'h00, "model_d12_b0", model_q[0], 8'h00);
    check(model_q[1] == 8'h10, "model_d12_b1", model_q[1], 8'h10);
    check(model_q[2] == 8'h00, "model_d12_b2", model_q[2], 8'h00);
    check(model_q[3] == 8'h02, "model_d12_b3", model_q[3], 8'h02);
    check(model_q[4] == 8'h30, "model_d12_b4", model_q[4], 8'h30);
    for (int k = 0; k < 256; k++) coeffs[k] = 16'((k + 1) % 2);
    build_model(1);
    check(model_q.size() == 32, "model_d1_len", model_q.size(), 32);
    check(model_q[0] == 8'h55 && model_q[31] == 8'h55, "model_d1_bytes", model_q[31], 8'h55);

    // d=1 alternating pattern, full-rate ready.
    run_poly(1, 256, -1, 1'b0);

    // d=12 ramp, with a start pulse mid-run that must be ignored.
    for (int k = 0; k < 256; k++) coeffs[k] = 16'(k);
    run_poly(12, 256, 50, 1'b1);

    // d=12 with an out-of-range first coefficient.
    coeffs[0] = 16'd3329;
    build_model(12);
    check(model_q[0] == 8'h01, "model_d12_q_b0", model_q[0], 8'h01);
    run_poly(12, 256, -1, 1'b0);

    // d=4 all-ones container under random backpressure.
    for (int k = 0; k < 256; k++) coeffs[k] = 16'hFFFF;
    build_model(4);
    check(model_q.size() == 128 && model_q[127] == 8'hFF, "model_d4_ff", model_q[127], 8'hFF);
    rand_ready = 1'b1;
    run_poly(4, 256, -1, 1'b1);

    cfg_bad(0);
    cfg_bad(13);

    // Reset mid-polynomial, then a fresh d=5 stream.
    for (int k = 0; k < 256; k++) coeffs[k] = 16'($urandom);
    run_poly(10, 100, -1, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 256; k++) coeffs[k] = 16'($urandom);
    run_poly(5, 256, -1, 1'b1);

    // Random widths and data.
    for (int r = 0; r < 4; r++) begin
      rd = int'($urandom_range(12, 1));
      for (int k = 0; k < 256; k++) coeffs[k] = 16'($urandom);
      run_poly(rd, 256, -1, 1'b1);
    end

    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
